heartbeat_pulse_gen: RTL and testbench

Synthetic heartbeat source. It converts a binary BPM setting into a periodic pulse train, which drives the pulse monitor's pulse_in during bring-up and self-test, so the monitor's BPM readout can be checked against a known rate. The beat period is computed on-chip by an iterative divider. Output polarity and pulse width match the sensor front end.

---
 rtl/heartbeat_pulse_gen.sv | 153 +++++++++++++++
 tb/tb_heartbeat_pulse_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_pulse_gen.sv
// Synthetic heartbeat source: turns a BPM setting into a periodic pulse train.
// The beat period CLK_HZ*60/bpm is produced by a 33-bit restoring divider.
`timescale 1ns/1ps
module heartbeat_pulse_gen #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned PULSE_MS = 50,
    parameter int unsigned BPM_MAX  = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  bpm,
    output logic        pulse_out,
    output logic        beat_stb,
    output logic [7:0]  cur_bpm,
    output logic [15:0] beat_count
);

    localparam longint unsigned DIVIDEND_L = 64'(CLK_HZ) * 64'd60;
    localparam longint unsigned PULSE_L    = 64'(CLK_HZ) * 64'(PULSE_MS) / 64'd1000;
    localparam logic [32:0]     DIVIDEND   = 33'(DIVIDEND_L);
    localparam logic [32:0]     HIGH_LAST  = 33'(PULSE_L - 64'd1);
    localparam logic [7:0]      BPM_CLAMP  = 8'(BPM_MAX);
    localparam logic [5:0]      DIV_STEPS  = 6'd33;

    // The divider must finish while the pulse is still high, and the pulse
    // must end before the shortest allowed period.
    if (PULSE_L <= 64'd34) begin : g_bad_pulse_short
        $error("PULSE_CYC must exceed the 34-cycle divider latency");
    end
    if (PULSE_L >= DIVIDEND_L / 64'(BPM_MAX)) begin : g_bad_pulse_long
        $error("PULSE_CYC must be shorter than the period at BPM_MAX");
    end
    if (BPM_MAX == 0 || BPM_MAX > 255) begin : g_bad_bpm_max
        $error("BPM_MAX must be in 1..255");
    end
    if (DIVIDEND_L >= 64'h2_0000_0000) begin : g_bad_clk
        $error("CLK_HZ*60 must fit in 33 bits");
    end

    function automatic logic [7:0] clamp_bpm(input logic [7:0] req);
        return (req > BPM_CLAMP) ? BPM_CLAMP : req;
    endfunction

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t      state;
    logic [32:0] phase;
    logic [32:0] period;
    logic [32:0] period_last;
    logic [7:0]  eff_bpm;
    logic        start_ok;
    logic        rise;

    logic        div_busy;
    logic [5:0]  div_step;
    logic [32:0] div_acc;
    logic [7:0]  div_rem;
    logic [7:0]  div_den;
    logic [8:0]  rem_shift;
    logic        rem_ge;
    logic [7:0]  rem_next;

    assign eff_bpm     = clamp_bpm(bpm);
    assign start_ok    = en && (bpm != 8'd0);
    assign period_last = period - 33'd1;
    // A beat starts from IDLE, or back-to-back at the last cycle of a period.
    assign rise        = start_ok &&
                         ((state == IDLE) || ((state == LOW) && (phase == period_last)));

    assign rem_shift = {div_rem, div_acc[32]};
    assign rem_ge    = rem_shift >= {1'b0, div_den};
    assign rem_next  = rem_ge ? 8'(rem_shift - {1'b0, div_den}) : rem_shift[7:0];

    // Divider control: one quotient bit per cycle, result written on the 34th edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_busy <= 1'b0;
            div_step <= 6'd0;
        end else if (rise) begin
            div_busy <= 1'b1;
            div_step <= 6'd0;
        end else if (div_busy) begin
            if (div_step == DIV_STEPS) begin
                div_busy <= 1'b0;
            end else begin
                div_step <= div_step + 6'd1;
            end
        end
    end

    // Divider datapath: quotient bits shift into the dividend register.
    always_ff @(posedge clk) begin
        if (rise) begin
            div_acc <= DIVIDEND;
            div_rem <= 8'd0;
            div_den <= eff_bpm;
        end else if (div_busy && (div_step != DIV_STEPS)) begin
            div_acc <= {div_acc[31:0], rem_ge};
            div_rem <= rem_next;
        end
        if (div_busy && (div_step == DIV_STEPS)) begin
            period <= div_acc;
        end
    end

    // Beat sequencer: phase counts cycles since the current rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pulse_out  <= 1'b0;
            beat_stb   <= 1'b0;
            cur_bpm    <= 8'd0;
            beat_count <= 16'd0;
            phase      <= 33'd0;
        end else begin
            beat_stb <= 1'b0;
            if (rise) begin
                state      <= HIGH;
                pulse_out  <= 1'b1;
                beat_stb   <= 1'b1;
                cur_bpm    <= eff_bpm;
                beat_count <= beat_count + 16'd1;
                phase      <= 33'd0;
            end else begin
                case (state)
                    IDLE: begin
                        pulse_out <= 1'b0;
                    end
                    HIGH: begin
                        phase <= phase + 33'd1;
                        if (phase == HIGH_LAST) begin
                            state     <= LOW;
                            pulse_out <= 1'b0;
                        end
                    end
                    LOW: begin
                        if (phase == period_last) begin
                            state <= IDLE;
                        end else begin
                            phase <= phase + 33'd1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Scoreboard bench for heartbeat_pulse_gen: a time-based beat model predicts
// every cycle's outputs; a monitor compares them one cycle at a time.
`timescale 1ns/1ps
module tb_heartbeat_pulse_gen;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned PULSE_MS  = 50;
    localparam int unsigned BPM_MAX   = 240;
    localparam longint      PULSE_CYC = longint'(CLK_HZ) * PULSE_MS / 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [7:0]  bpm = 8'd0;
    logic        pulse_out;
    logic        beat_stb;
    logic [7:0]  cur_bpm;
    logic [15:0] beat_count;

    heartbeat_pulse_gen #(
        .CLK_HZ  (CLK_HZ),
        .PULSE_MS(PULSE_MS),
        .BPM_MAX (BPM_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bpm       (bpm),
        .pulse_out (pulse_out),
        .beat_stb  (beat_stb),
        .cur_bpm   (cur_bpm),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        s;
        logic [7:0]  c;
        logic [15:0] n;
        longint      e;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference: a beat is described by its start edge and period; outputs
    // follow from elapsed time since the start.
    longint      m_edge   = 0;
    longint      m_start  = 0;
    longint      m_period = 0;
    bit          m_active = 0;
    logic [7:0]  m_cur    = 8'd0;
    logic [15:0] m_count  = 16'd0;

    task automatic new_beat(input int eff);
        m_active = 1;
        m_start  = m_edge;
        m_period = (longint'(CLK_HZ) * 60) / eff;
        m_cur    = 8'(eff);
        m_count  = m_count + 16'd1;
    endtask

    task automatic model_step(input logic r, input logic e_, input logic [7:0] b);
        exp_t x;
        bit   go;
        int   eff;
        m_edge++;
        go  = e_ && (b != 8'd0);
        eff = (int'(b) > int'(BPM_MAX)) ? int'(BPM_MAX) : int'(b);
        if (!r) begin
            m_active = 0;
            m_cur    = 8'd0;
            m_count  = 16'd0;
        end else if (m_active && (m_edge - m_start == m_period)) begin
            if (go) new_beat(eff);
            else    m_active = 0;
        end else if (!m_active && go) begin
            new_beat(eff);
        end
        x.p = m_active && (m_edge - m_start < PULSE_CYC);
        x.s = m_active && (m_edge == m_start);
        x.c = m_cur;
        x.n = m_count;
        x.e = m_edge;
        expq.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic e_, input logic [7:0] b);
        @(negedge clk);
        rst = r;
        en  = e_;
        bpm = b;
        model_step(r, e_, b);
    endtask

    task automatic run(input int n, input logic e_, input logic [7:0] b);
        for (int i = 0; i < n; i++) cyc(1'b1, e_, b);
    endtask

    // Advance until the model is at the given phase of an active beat.
    task automatic run_to_phase(input longint ph, input logic e_, input logic [7:0] b);
        int guard = 0;
        while (!(m_active && (m_edge - m_start == ph)) && guard < 70000) begin
            cyc(1'b1, e_, b);
            guard++;
        end
        if (guard >= 70000) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_to_phase: phase %0d not reached within %0d cycles", ph, guard);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                n_cmp++;
                if (pulse_out !== x.p || beat_stb !== x.s || cur_bpm !== x.c || beat_count !== x.n) begin
                    n_err++;
                    $display("FAIL outputs edge %0d: got pulse=%0b stb=%0b cur_bpm=%0d count=%0d, expected pulse=%0b stb=%0b cur_bpm=%0d count=%0d",
                             x.e, pulse_out, beat_stb, cur_bpm, beat_count, x.p, x.s, x.c, x.n);
                end
            end
        end
    end

    initial begin : stimulus
        int          len;
        int          sel;
        logic        en_r;
        logic [7:0]  b_r;

        // Reset state
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'd0);
        run(3, 1'b0, 8'd60);

        // Steady 60 BPM: period 1000, high 50
        run(3100, 1'b1, 8'd60);

        // Maximum rate, clamped rate, slow rate
        run(800, 1'b1, 8'd240);
        run(800, 1'b1, 8'd250);
        run(9000, 1'b1, 8'd7);

        // Rate change mid-beat takes effect on the next beat
        run_to_phase(0, 1'b1, 8'd60);
        run_to_phase(400, 1'b1, 8'd60);
        run(2200, 1'b1, 8'd120);

        // en dropped early in a beat: full beat, then idle
        run_to_phase(0, 1'b1, 8'd60);
        run(10, 1'b1, 8'd60);
        run(1200, 1'b0, 8'd60);
        // bpm=0 at a boundary stops generation
        run(300, 1'b1, 8'd60);
        run_to_phase(200, 1'b1, 8'd60);
        run(900, 1'b1, 8'd0);
        // en dropped then restored before the boundary: seamless
        run(5, 1'b1, 8'd200);
        run_to_phase(100, 1'b1, 8'd200);
        run(50, 1'b0, 8'd200);
        run(600, 1'b1, 8'd200);

        // Reset during the high phase, then restart
        run_to_phase(20, 1'b1, 8'd90);
        cyc(1'b0, 1'b1, 8'd90);
        run(3, 1'b0, 8'd90);
        run(1500, 1'b1, 8'd90);

        // Randomized segments: rate changes, en toggles, occasional resets
        for (int seg = 0; seg < 30; seg++) begin
            len  = $urandom_range(200, 2000);
            en_r = ($urandom_range(0, 9) != 0);
            sel  = $urandom_range(0, 9);
            if (sel == 0)      b_r = 8'd0;
            else if (sel == 1) b_r = 8'($urandom_range(241, 255));
            else if (sel == 2) b_r = 8'($urandom_range(1, 20));
            else               b_r = 8'($urandom_range(21, 240));
            if ($urandom_range(0, 14) == 0) cyc(1'b0, en_r, b_r);
            run(len, en_r, b_r);
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected entries left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
